ram_scan_reader: RTL and testbench



---
 rtl/ram_scan_reader.sv | 129 ++++++++++++
 tb/tb_ram_scan_reader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - sequential RAM scanner that captures and holds each word for display
//
// Walks RAM addresses 0 .. 2^ADDR_WIDTH-1 in order. For each address it waits
// READ_LATENCY edges for the read data, captures it, then holds it for
// DWELL_CYCLES enabled cycles (free-run) or until a step pulse.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   1 = free-run (advance after dwell), 0 = paused
//   step       in   single-cycle pulse, advances one address while showing
//   rd_addr    out  registered RAM read address
//   rd_data    in   RAM read data
//   cur_addr   out  address of the word currently held (same as rd_addr)
//   cur_data   out  captured word for display
//   data_valid out  high while cur_data belongs to cur_addr
//   wrapped    out  one-cycle pulse on the cycle rd_addr returns to 0

module ram_scan_reader #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 4,
   parameter int READ_LATENCY = 2,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] cur_addr,
   output logic [DATA_WIDTH-1:0] cur_data,
   output logic                  data_valid,
   output logic                  wrapped
);

   localparam int WAIT_W  = $clog2(READ_LATENCY + 1);
   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

   localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(READ_LATENCY - 1);
   localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   state_t                  state_q,      state_d;
   logic [WAIT_W-1:0]       wait_cnt_q,   wait_cnt_d;
   logic [DWELL_W-1:0]      dwell_cnt_q,  dwell_cnt_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q,    rd_addr_d;
   logic [DATA_WIDTH-1:0]   cur_data_q,   cur_data_d;
   logic                    data_valid_q, data_valid_d;
   logic                    wrapped_q,    wrapped_d;

   logic                    advance;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      dwell_cnt_d  = dwell_cnt_q;
      rd_addr_d    = rd_addr_q;
      cur_data_d   = cur_data_q;
      data_valid_d = data_valid_q;
      // wrapped is a pulse: it is only ever set on the advance edge itself
      wrapped_d    = 1'b0;
      advance      = 1'b0;

      case (state_q)
         ST_WAIT: begin
            // step is deliberately not looked at here; steps are never queued
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
               cur_data_d   = rd_data;
               data_valid_d = 1'b1;
               dwell_cnt_d  = '0;
               state_d      = ST_SHOW;
            end
         end

         ST_SHOW: begin
            // A step skips whatever dwell is left, even while paused
            advance = step || (enable && (dwell_cnt_q == DWELL_LAST));
            if (advance) begin
               rd_addr_d    = rd_addr_q + 1'b1;
               wrapped_d    = (rd_addr_q == ADDR_MAX);
               data_valid_d = 1'b0;
               wait_cnt_d   = '0;
               state_d      = ST_WAIT;
            end else if (enable) begin
               dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
            // enable low: dwell progress is frozen, not discarded
         end

         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_WAIT;
         wait_cnt_q   <= '0;
         dwell_cnt_q  <= '0;
         rd_addr_q    <= '0;
         cur_data_q   <= '0;
         data_valid_q <= 1'b0;
         wrapped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         dwell_cnt_q  <= dwell_cnt_d;
         rd_addr_q    <= rd_addr_d;
         cur_data_q   <= cur_data_d;
         data_valid_q <= data_valid_d;
         wrapped_q    <= wrapped_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign cur_addr   = rd_addr_q;
   assign cur_data   = cur_data_q;
   assign data_valid = data_valid_q;
   assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - self-checking bench for ram_scan_reader

module tb_ram_scan_reader;

   localparam int AW    = 5;
   localparam int DW    = 4;
   localparam int RL    = 2;
   localparam int DWELL = 4;
   localparam int NADDR = 1 << AW;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          step;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_data;
   logic          data_valid;
   logic          wrapped;

   int checks;
   int failures;

   ram_scan_reader #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .READ_LATENCY(RL),
      .DWELL_CYCLES(DWELL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .step      (step),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .cur_addr  (cur_addr),
      .cur_data  (cur_data),
      .data_valid(data_valid),
      .wrapped   (wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: registered output, so data for an address presented at edge E is
   // sampleable at edge E+2 and the previous address's word is seen at E+1.
   logic [DW-1:0] mem [NADDR];
   initial begin
      for (int a = 0; a < NADDR; a++) begin
         logic [3:0] a4;
         a4 = 4'(a);
         mem[a] = ~a4;
      end
   end
   always @(posedge clk) rd_data <= mem[rd_addr];

   // Reference model: tracks edges since the last advance and enabled cycles
   // spent showing, and derives the displayed word straight from the RAM rule.
   int         m_addr;
   int         m_since;
   int         m_dwell;
   bit         m_valid;
   logic [3:0] m_data;
   bit         m_wrap;

   task automatic model_edge();
      logic [3:0] a4;
      if (reset) begin
         m_addr = 0; m_since = 0; m_dwell = 0;
         m_valid = 0; m_data = 4'h0; m_wrap = 0;
      end else if (!m_valid) begin
         m_wrap  = 0;
         m_since = m_since + 1;
         if (m_since == RL) begin
            a4      = 4'(m_addr);
            m_data  = ~a4;
            m_valid = 1;
            m_dwell = 0;
         end
      end else if (step || (enable && m_dwell == DWELL - 1)) begin
         m_wrap  = (m_addr == NADDR - 1);
         m_addr  = (m_addr + 1) % NADDR;
         m_valid = 0;
         m_since = 0;
      end else begin
         m_wrap = 0;
         if (enable) m_dwell = m_dwell + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Advances until a capture edge (data_valid 0 -> 1); ok=0 on timeout.
   task automatic wait_capture(output bit ok);
      int n;
      ok = 0;
      n  = 0;
      while (data_valid === 1'b1 && n < 300) begin tick(); n++; end
      while (data_valid !== 1'b1 && n < 300) begin tick(); n++; end
      ok = (data_valid === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1; enable = 1; step = 0;
      tick(); tick();
      checks++;
      if ({rd_addr, cur_addr, cur_data, data_valid, wrapped} !== '0) begin
         failures++;
         $display("FAIL reset_state actual addr=%0d cur=%0d data=%h valid=%b wrap=%b required all zero",
                  rd_addr, cur_addr, cur_data, data_valid, wrapped);
      end
   endtask

   task automatic test_reset_then_run();
      reset = 0; enable = 1; step = 0;
      tick();
      checks++;
      if (data_valid !== 1'b0) begin
         failures++; $display("FAIL first_edge_valid actual=%b required=0", data_valid);
      end
      tick();
      checks++;
      if (data_valid !== 1'b1 || cur_addr !== 5'd0 || cur_data !== 4'hF) begin
         failures++;
         $display("FAIL first_capture actual valid=%b addr=%0d data=%h required valid=1 addr=0 data=f",
                  data_valid, cur_addr, cur_data);
      end
      for (int i = 0; i < DWELL - 1; i++) tick();
      checks++;
      if (rd_addr !== 5'd0 || data_valid !== 1'b1) begin
         failures++; $display("FAIL early_advance actual addr=%0d valid=%b required addr=0 valid=1", rd_addr, data_valid);
      end
      tick();
      checks++;
      if (rd_addr !== 5'd1 || data_valid !== 1'b0) begin
         failures++; $display("FAIL first_advance actual addr=%0d valid=%b required addr=1 valid=0", rd_addr, data_valid);
      end
      tick(); tick();
      checks++;
      if (data_valid !== 1'b1 || cur_data !== 4'hE) begin
         failures++; $display("FAIL second_capture actual valid=%b data=%h required valid=1 data=e", data_valid, cur_data);
      end
   endtask

   task automatic test_full_scan();
      int         wrap_cycles;
      bit         saw31;
      logic [AW-1:0] prev, old;
      enable = 1; step = 0;
      wrap_cycles = 0; saw31 = 0;
      prev = rd_addr;
      for (int n = 0; n < NADDR * (RL + DWELL) + 12; n++) begin
         tick();
         old = prev;
         if (rd_addr !== prev) begin
            checks++;
            if (rd_addr !== AW'(prev + 1)) begin
               failures++; $display("FAIL scan_sequence actual=%0d required=%0d", rd_addr, AW'(prev + 1));
            end
            prev = rd_addr;
         end
         if (wrapped === 1'b1) begin
            wrap_cycles++;
            checks++;
            if (rd_addr !== 5'd0 || old !== 5'd31) begin
               failures++; $display("FAIL wrap_alignment actual addr=%0d from=%0d required addr=0 from=31", rd_addr, old);
            end
         end
         if (!saw31 && rd_addr === 5'd31 && data_valid === 1'b1) begin
            saw31 = 1;
            checks++;
            if (cur_data !== 4'h0) begin
               failures++; $display("FAIL data_at_31 actual=%h required=0", cur_data);
            end
         end
      end
      checks++;
      if (wrap_cycles != 1 || !saw31) begin
         failures++; $display("FAIL wrap_pulse_count actual=%0d saw31=%0b required=1 saw31=1", wrap_cycles, saw31);
      end
   endtask

   task automatic test_pause_resume();
      bit            ok;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      enable = 1; step = 0;
      wait_capture(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL pause_capture_timeout actual=0 required=1"); end
      tick(); tick();
      a0 = rd_addr; d0 = cur_data;
      enable = 0;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (rd_addr !== a0 || cur_data !== d0 || data_valid !== 1'b1) begin
         failures++;
         $display("FAIL pause_hold actual addr=%0d data=%h valid=%b required addr=%0d data=%h valid=1",
                  rd_addr, cur_data, data_valid, a0, d0);
      end
      enable = 1;
      tick();
      checks++;
      if (rd_addr !== a0) begin
         failures++; $display("FAIL resume_early actual=%0d required=%0d", rd_addr, a0);
      end
      tick();
      checks++;
      if (rd_addr !== AW'(a0 + 1)) begin
         failures++; $display("FAIL resume_advance actual=%0d required=%0d", rd_addr, AW'(a0 + 1));
      end
   endtask

   task automatic test_single_step();
      int n;
      enable = 0; step = 0;
      n = 0;
      while (!(rd_addr === 5'd5 && data_valid === 1'b1) && n < 200) begin
         if (data_valid === 1'b1) begin
            step = 1; tick(); step = 0;
         end else begin
            tick();
         end
         n++;
      end
      checks++;
      if (rd_addr !== 5'd5 || data_valid !== 1'b1) begin
         failures++; $display("FAIL step_reach_5 actual addr=%0d valid=%b required addr=5 valid=1", rd_addr, data_valid);
      end
      step = 1; tick(); step = 0;
      checks++;
      if (rd_addr !== 5'd6 || data_valid !== 1'b0) begin
         failures++; $display("FAIL step_advance actual addr=%0d valid=%b required addr=6 valid=0", rd_addr, data_valid);
      end
      step = 1; tick(); step = 0;
      checks++;
      if (rd_addr !== 5'd6 || data_valid !== 1'b0) begin
         failures++; $display("FAIL step_in_wait actual addr=%0d valid=%b required addr=6 valid=0", rd_addr, data_valid);
      end
      tick();
      checks++;
      if (rd_addr !== 5'd6 || data_valid !== 1'b1 || cur_data !== 4'h9) begin
         failures++;
         $display("FAIL step_capture actual addr=%0d valid=%b data=%h required addr=6 valid=1 data=9",
                  rd_addr, data_valid, cur_data);
      end
   endtask

   task automatic test_step_free_run();
      bit            ok;
      logic [AW-1:0] a0;
      enable = 1; step = 0;
      wait_capture(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL freerun_capture_timeout actual=0 required=1"); end
      tick();
      a0 = rd_addr;
      step = 1; tick(); step = 0;
      checks++;
      if (rd_addr !== AW'(a0 + 1) || data_valid !== 1'b0) begin
         failures++; $display("FAIL freerun_step actual addr=%0d valid=%b required addr=%0d valid=0", rd_addr, data_valid, AW'(a0 + 1));
      end
      tick(); tick();
      for (int i = 0; i < DWELL - 1; i++) tick();
      checks++;
      if (rd_addr !== AW'(a0 + 1) || data_valid !== 1'b1) begin
         failures++; $display("FAIL freerun_no_double actual addr=%0d valid=%b required addr=%0d valid=1", rd_addr, data_valid, AW'(a0 + 1));
      end
      tick();
      checks++;
      if (rd_addr !== AW'(a0 + 2)) begin
         failures++; $display("FAIL freerun_next_dwell actual=%0d required=%0d", rd_addr, AW'(a0 + 2));
      end
   endtask

   task automatic test_reset_mid();
      int n;
      enable = 1; step = 0;
      n = 0;
      while (!(rd_addr === 5'd12 && data_valid === 1'b0) && n < 400) begin tick(); n++; end
      checks++;
      if (rd_addr !== 5'd12 || data_valid !== 1'b0) begin
         failures++; $display("FAIL reach_12_wait actual addr=%0d valid=%b required addr=12 valid=0", rd_addr, data_valid);
      end
      reset = 1; tick(); reset = 0;
      checks++;
      if (rd_addr !== 5'd0 || data_valid !== 1'b0 || wrapped !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset actual addr=%0d valid=%b wrap=%b required addr=0 valid=0 wrap=0",
                  rd_addr, data_valid, wrapped);
      end
      tick();
      tick();
      checks++;
      if (data_valid !== 1'b1 || cur_addr !== 5'd0 || cur_data !== 4'hF) begin
         failures++;
         $display("FAIL restart_capture actual valid=%b addr=%0d data=%h required valid=1 addr=0 data=f",
                  data_valid, cur_addr, cur_data);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         reset  = ($urandom_range(0, 149) == 0);
         enable = ($urandom_range(0, 3) != 0);
         step   = ($urandom_range(0, 5) == 0);
         tick();
         checks++;
         if ({rd_addr, cur_addr, cur_data, data_valid, wrapped} !==
             {AW'(m_addr), AW'(m_addr), m_data, m_valid, m_wrap}) begin
            failures++;
            $display("FAIL random_cycle_%0d actual addr=%0d cur=%0d data=%h valid=%b wrap=%b required addr=%0d data=%h valid=%b wrap=%b",
                     n, rd_addr, cur_addr, cur_data, data_valid, wrapped, m_addr, m_data, m_valid, m_wrap);
         end
      end
      reset = 0; enable = 0; step = 0;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1; enable = 0; step = 0;
      test_reset();
      test_reset_then_run();
      test_full_scan();
      test_pause_resume();
      test_single_step();
      test_step_free_run();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
